// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake for the pipeline stall logic.

module mdu_rca #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

module mul_div_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Result,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(n);
  localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       neg;
  } ctl_t;

  state_t          state, state_nx;
  ctl_t            ctl;
  logic [2*n-1:0]  acc;
  logic [n-1:0]    opb;
  logic [CW-1:0]   cnt;

  // operand decode at acceptance
  logic         a_sgn, b_sgn, div_by0, ovf, special, neg_in, accept;
  logic [n-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    a_sgn    = A[n-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                         funct3 == 3'b100 || funct3 == 3'b110);
    b_sgn    = B[n-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    a_mag    = a_sgn ? -A : A;
    b_mag    = b_sgn ? -B : B;
    neg_in   = (funct3 == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);
    div_by0  = funct3[2] & (B == '0);
    ovf      = funct3[2] & ~funct3[0] & (A == MIN_NEG) & (B == '1);
    special  = div_by0 | ovf;
    spec_res = '0;
    if (div_by0)  spec_res = funct3[1] ? A : '1;
    else if (ovf) spec_res = funct3[1] ? '0 : MIN_NEG;
    accept   = (state == IDLE) & start & ~kill;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (kill) state_nx = IDLE;
               else if (cnt == CW'(n-1)) state_nx = FIX;
      FIX:     state_nx = kill ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CALC) | (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // one adder shared: multiply accumulates, divide trial-subtracts via ~d + 1
  logic [n:0] add_a, add_b, add_s;
  logic       add_ci, add_co;

  always_comb begin
    if (ctl.op[2]) begin
      add_a  = {acc[2*n-1:n], acc[n-1]};
      add_b  = ~{1'b0, opb};
      add_ci = 1'b1;
    end else begin
      add_a  = {1'b0, acc[2*n-1:n]};
      add_b  = {1'b0, opb} & {(n+1){acc[0]}};
      add_ci = 1'b0;
    end
  end

  mdu_rca #(.W(n+1)) u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co)
  );

  logic [2*n-1:0] prod;
  logic [n-1:0]   dsel, fix_res;

  always_comb begin
    prod = ctl.neg ? -acc : acc;
    dsel = ctl.op[1] ? acc[2*n-1:n] : acc[n-1:0];
    if (ctl.op[2])                fix_res = ctl.neg ? -dsel : dsel;
    else if (ctl.op[1:0] == 2'b00) fix_res = prod[n-1:0];
    else                          fix_res = prod[2*n-1:n];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl    <= '0;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ctl.op  <= funct3;
          ctl.neg <= neg_in;
          opb     <= b_mag;
          acc     <= {{n{1'b0}}, a_mag};
          cnt     <= '0;
          if (special) Result <= spec_res;
        end
        CALC: if (!kill) begin
          cnt <= cnt + 1'b1;
          if (!ctl.op[2])  acc <= {add_s, acc[n-1:1]};
          else if (add_co) acc <= {add_s[n-1:0], acc[n-2:0], 1'b1};
          else             acc <= {acc[2*n-2:0], 1'b0};
        end
        FIX: if (!kill) Result <= fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic, special cases, latency, kill/reset, handshake.

module tb_mul_div_unit;
  logic        clk, rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] A, B, Result;
  logic        busy, done;
  int          errors = 0;
  int          checks = 0;

  mul_div_unit #(.n(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .A(A), .B(B), .Result(Result), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; funct3 = 3'($urandom);
  endtask

  // entered at the negedge of cycle 1 after acceptance
  task automatic wait_done(output int cyc, output int bc);
    cyc = 1; bc = 0;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc, bc;
    issue(f, a, b);
    wait_done(cyc, bc);
    chk({tag, "_res"}, Result, exp);
    chk({tag, "_lat"}, cyc, lat);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int cyc, bc, cnt;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", Result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    // MUL 7 * -3 with latency and busy-length check
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(cyc, bc);
    chk("mul_res", Result, 32'hFFFF_FFEB);
    chk("mul_lat", cyc, 34);
    chk("mul_busy", bc, 33);
    @(negedge clk);
    chk("mul_pulse", {31'b0, done}, 32'd0);

    run("mul2",   3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
    run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("rem2",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    run("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34);
    run("divu1",  3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34);
    run("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         1);
    run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34);

    // kill during CALC cycle 10
    issue(3'b000, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_done", {31'b0, done}, 32'd0);
    chk("kill_result", Result, 32'd14);
    count_done(40, cnt);
    chk("kill_nodone", cnt, 0);
    chk("kill_result_hold", Result, 32'd14);

    // asynchronous reset mid-CALC
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_result", Result, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, cnt);
    chk("arst_nodone", cnt, 0);

    // start held through the op, operands changed during CALC, then back-to-back
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; A = 32'd100; B = 32'd7;
    @(negedge clk);
    funct3 = 3'b000; A = 32'd3; B = 32'd1;
    wait_done(cyc, bc);
    chk("hold_res", Result, 32'd14);
    chk("hold_lat", cyc, 34);
    funct3 = 3'b000; A = 32'd7; B = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("hold_one_done", {31'b0, done}, 32'd0);
    chk("b2b_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("b2b_accept", {31'b0, busy}, 32'd1);
    start = 1'b0; A = 32'd11; B = 32'd13;
    wait_done(cyc, bc);
    chk("b2b_res", Result, 32'hFFFF_FFEB);
    chk("b2b_lat", cyc, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
